wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back stage that sits directly upstream of the 32x32 register file and drives its write port (RegWrite, Write_addr, Write_data).
- Accepts retiring instructions from the MEM stage through a valid/ready handshake.
- ALU results are written immediately. For loads, the stage waits for the data cache response, then extracts the byte, half or word, extends it to 32 bits, and writes it.
- Exports the pending load destination to the hazard unit and raises a sticky error if the cache response times out.

Parameters:
- DATA_W, 32, register and data width.
- TIMEOUT, 64, maximum cycles to wait for dcache_rvalid after a load is accepted. Must be at least 2.
- CNT_W, 7, width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_regwrite  in  1  instruction writes a register
- in_memtoreg  in  1  1 = load, 0 = ALU result
- in_dest  in  5  destination register
- in_alu  in  DATA_W  ALU result; for loads, low 2 bits are the byte offset
- in_ld_size  in  2  00 = byte, 01 = half, 10 = word, 11 = treated as word
- in_ld_unsigned  in  1  zero-extend (1) or sign-extend (0)
- dcache_rvalid  in  1  load data valid
- dcache_rdata  in  DATA_W  aligned word from the cache
- rf_we  out  1  to regfile RegWrite
- rf_waddr  out  5  to regfile Write_addr
- rf_wdata  out  DATA_W  to regfile Write_data
- pend_valid  out  1  a load is outstanding
- pend_dest  out  5  destination of the outstanding load
- stall  out  1  equals ~in_ready
- timeout_err  out  1  sticky; set when a cache response times out
- retire_cnt  out  32  instructions retired, wraps modulo 2^32

Behaviour:
- Reset (async): state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, pend_valid=0, pend_dest=0, timeout_err=0, retire_cnt=0, timer=0.
- FSM states:
  - IDLE: in_ready=1.
  - WAIT_LOAD: in_ready=0.
- Accept occurs when in_valid && in_ready on a rising edge.
- IDLE, accept with in_memtoreg=0:
  - Next cycle: rf_we = in_regwrite && (in_dest != 0); rf_waddr=in_dest; rf_wdata=in_alu.
  - retire_cnt increments. Latency is 1 cycle.
- IDLE, accept with in_memtoreg=1:
  - Latch dest, size, unsigned, offset=in_alu[1:0] and regwrite.
  - Go to WAIT_LOAD with timer=0 and rf_we=0.
  - pend_valid = in_regwrite && (in_dest != 0); pend_dest=in_dest. Both are registered and visible the cycle after accept.
- Any cycle without a write: rf_we=0. rf_we is a single-cycle pulse per write. rf_waddr and rf_wdata hold their last values.
- WAIT_LOAD, each cycle without dcache_rvalid: timer increments.
- WAIT_LOAD, dcache_rvalid=1:
  - Next cycle: rf_we = latched regwrite && dest != 0; rf_wdata = extracted data.
  - Return to IDLE; pend_valid=0; retire_cnt increments.
  - A new instruction can be accepted in the first cycle back in IDLE.
- WAIT_LOAD, timer reaches TIMEOUT-1 with no rvalid:
  - On that edge: timeout_err=1 (sticky until rst), no write, pend_valid=0.
  - Return to IDLE; retire_cnt increments.
  - dcache_rvalid arriving in the same cycle as the timeout wins: the load completes normally and no error is raised.
- Extraction (little-endian), using the latched offset:
  - Byte: lane = rdata[8*off +: 8].
  - Half: lane = rdata[16*off[1] +: 16]; off[0] is ignored.
  - Word: full rdata; offset is ignored.
  - Sign-extend from the lane MSB, or zero-extend, per the latched unsigned flag.
- dcache_rvalid in IDLE, including the accept cycle of a load, is ignored. The load samples rvalid from the cycle after accept onward.
- Destination 0 is never written; the instruction still retires and counts.
- rst asserted during WAIT_LOAD: the load is abandoned and no write occurs. A late rvalid after reset is ignored.

Test Plan:
- Reset, then ALU instruction dest=5, alu=0xDEADBEEF, regwrite=1 -> next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF; retire_cnt=1; the following cycle rf_we=0.
- Load byte signed, dest=3, off=2; rvalid 3 cycles after accept with rdata=0x12F45678 -> in_ready=0, pend_valid=1, pend_dest=3 while waiting; one cycle after rvalid rf_we=1, waddr=3, wdata=0xFFFFFFF4; then in_ready=1.
- Load half unsigned, off=2, rdata=0x8001ABCD -> wdata=0x00008001. Load half signed, off=0, same rdata -> wdata=0xFFFFABCD.
- ALU instruction dest=0 regwrite=1 -> rf_we stays 0, retire_cnt increments. Word load whose rvalid pulses in the accept cycle and again 2 cycles later -> only the later rvalid data is written.
- Load with no rvalid for TIMEOUT=64 cycles -> at cycle 64 timeout_err=1, no rf_we, pend_valid=0, state IDLE. Repeat with rvalid arriving exactly in cycle 64 -> normal write, timeout_err=0.
- rst asserted mid-WAIT_LOAD, then rvalid arrives -> all outputs 0, no write. Back-to-back ALU instructions every cycle -> rf_we high every cycle, retire_cnt matches the number of instructions.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage feeding the register-file write port: ALU results retire in
// one cycle, loads wait for the data-cache response, then the lane is extracted and extended.
module wb_stage #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_regwrite,
    input  logic              in_memtoreg,
    input  logic [4:0]        in_dest,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_unsigned,
    input  logic              dcache_rvalid,
    input  logic [DATA_W-1:0] dcache_rdata,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pend_valid,
    output logic [4:0]        pend_dest,
    output logic              stall,
    output logic              timeout_err,
    output logic [31:0]       retire_cnt,
    output logic [0:0]        fsm_state
);

    // Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
    // in_valid holds no obligation while in_ready is low, and in_ready never depends on in_valid.
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]        state;
    logic [CNT_W-1:0]  timer;
    logic [4:0]        ld_dest;
    logic [1:0]        ld_size;
    logic              ld_uns;
    logic [1:0]        ld_off;
    logic              ld_rw;
    logic              accept;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [DATA_W-1:0] ld_data;

    assign in_ready  = (state == S_IDLE);
    assign stall     = ~in_ready;
    assign accept    = in_valid && in_ready;
    assign fsm_state = state;

    // Little-endian lane pick from the aligned cache word using the offset latched at accept.
    assign lane_b = dcache_rdata[{ld_off, 3'b000} +: 8];
    assign lane_h = dcache_rdata[{ld_off[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = dcache_rdata;
        case (ld_size)
            2'b00: ld_data = ld_uns ? {{(DATA_W-8){1'b0}}, lane_b}
                                    : {{(DATA_W-8){lane_b[7]}}, lane_b};
            2'b01: ld_data = ld_uns ? {{(DATA_W-16){1'b0}}, lane_h}
                                    : {{(DATA_W-16){lane_h[15]}}, lane_h};
            default: ld_data = dcache_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            ld_dest     <= '0;
            ld_size     <= '0;
            ld_uns      <= 1'b0;
            ld_off      <= '0;
            ld_rw       <= 1'b0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            pend_valid  <= 1'b0;
            pend_dest   <= '0;
            timeout_err <= 1'b0;
            retire_cnt  <= '0;
        end else begin
            rf_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (!in_memtoreg) begin
                            rf_we      <= in_regwrite && (in_dest != 5'd0);
                            rf_waddr   <= in_dest;
                            rf_wdata   <= in_alu;
                            retire_cnt <= retire_cnt + 32'd1;
                        end else begin
                            ld_dest    <= in_dest;
                            ld_size    <= in_ld_size;
                            ld_uns     <= in_ld_unsigned;
                            ld_off     <= in_alu[1:0];
                            ld_rw      <= in_regwrite;
                            timer      <= '0;
                            pend_valid <= in_regwrite && (in_dest != 5'd0);
                            pend_dest  <= in_dest;
                            state      <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // A response in the final cycle takes priority over the timeout.
                    if (dcache_rvalid) begin
                        rf_we      <= ld_rw && (ld_dest != 5'd0);
                        rf_waddr   <= ld_dest;
                        rf_wdata   <= ld_data;
                        pend_valid <= 1'b0;
                        retire_cnt <= retire_cnt + 32'd1;
                        state      <= S_IDLE;
                    end else if (timer == CNT_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        pend_valid  <= 1'b0;
                        retire_cnt  <= retire_cnt + 32'd1;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: a vector table of ALU/load instructions plus
// hand-written timeout, reset and back-to-back sequences; writes are checked off an expected queue.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_regwrite;
    logic        in_memtoreg;
    logic [4:0]  in_dest;
    logic [31:0] in_alu;
    logic [1:0]  in_ld_size;
    logic        in_ld_unsigned;
    logic        dcache_rvalid;
    logic [31:0] dcache_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pend_valid;
    logic [4:0]  pend_dest;
    logic        stall;
    logic        timeout_err;
    logic [31:0] retire_cnt;
    logic [0:0]  fsm_state;

    wb_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
        .in_dest(in_dest), .in_alu(in_alu),
        .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
        .dcache_rvalid(dcache_rvalid), .dcache_rdata(dcache_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pend_valid(pend_valid), .pend_dest(pend_dest), .stall(stall),
        .timeout_err(timeout_err), .retire_cnt(retire_cnt), .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          ld;
        bit          rw;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] rdata;
        int          delay;
        bit          exp_we;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs[12];
    logic [36:0] exp_q[$];
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          write_cnt = 0;
    int          exp_retire = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // scoreboard: every rf_we pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst && rf_we) begin
            write_cnt++;
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", rf_waddr, rf_wdata);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("wr_addr", {27'd0, rf_waddr}, {27'd0, e[36:32]});
                check("wr_data", rf_wdata, e[31:0]);
            end
        end
    end

    // driver: called #1 after a rising edge, returns #1 after the retiring edge
    task automatic run_vec(input vec_t v);
        in_valid       = 1'b1;
        in_regwrite    = v.rw;
        in_memtoreg    = v.ld;
        in_dest        = v.dest;
        in_alu         = v.alu;
        in_ld_size     = v.size;
        in_ld_unsigned = v.uns;
        check("ready_idle", {31'd0, in_ready}, 32'd1);
        if (!v.ld && v.exp_we) exp_q.push_back({v.dest, v.exp_data});
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_retire++;
        if (v.ld) begin
            @(negedge clk);
            check("ld_in_ready", {31'd0, in_ready}, 32'd0);
            check("ld_stall", {31'd0, stall}, 32'd1);
            check("pend_valid", {31'd0, pend_valid}, {31'd0, v.exp_we});
            if (v.exp_we) check("pend_dest", {27'd0, pend_dest}, {27'd0, v.dest});
            repeat (v.delay - 1) @(negedge clk);
            dcache_rvalid = 1'b1;
            dcache_rdata  = v.rdata;
            if (v.exp_we) exp_q.push_back({v.dest, v.exp_data});
            @(posedge clk); #1;
            dcache_rvalid = 1'b0;
            check("ld_done_ready", {31'd0, in_ready}, 32'd1);
            check("ld_done_pend", {31'd0, pend_valid}, 32'd0);
        end
        check("retire_cnt", retire_cnt, exp_retire);
    endtask

    task automatic start_load(input logic [4:0] dest, input logic [1:0] size);
        in_valid = 1'b1; in_regwrite = 1'b1; in_memtoreg = 1'b1;
        in_dest = dest; in_alu = 32'h0; in_ld_size = size; in_ld_unsigned = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   wc;
        //          ld  rw dest   alu           size  uns rdata         dly we exp_data
        vecs[0]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 2'b00, 1'b0, 32'h0,        1, 1'b1, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b1, 5'd3,  32'h00000002, 2'b00, 1'b0, 32'h12F45678, 3, 1'b1, 32'hFFFFFFF4};
        vecs[2]  = '{1'b1, 1'b1, 5'd7,  32'h00000002, 2'b01, 1'b1, 32'h8001ABCD, 2, 1'b1, 32'h00008001};
        vecs[3]  = '{1'b1, 1'b1, 5'd8,  32'h00000000, 2'b01, 1'b0, 32'h8001ABCD, 1, 1'b1, 32'hFFFFABCD};
        vecs[4]  = '{1'b0, 1'b1, 5'd0,  32'h55555555, 2'b00, 1'b0, 32'h0,        1, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, 5'd9,  32'h00000001, 2'b00, 1'b1, 32'h12F45678, 4, 1'b1, 32'h00000056};
        vecs[6]  = '{1'b1, 1'b1, 5'd10, 32'h00000003, 2'b10, 1'b0, 32'h89ABCDEF, 2, 1'b1, 32'h89ABCDEF};
        vecs[7]  = '{1'b1, 1'b1, 5'd11, 32'h00000003, 2'b01, 1'b0, 32'h7FFF0000, 1, 1'b1, 32'h00007FFF};
        vecs[8]  = '{1'b1, 1'b1, 5'd12, 32'h00000003, 2'b00, 1'b0, 32'h80112233, 5, 1'b1, 32'hFFFFFF80};
        vecs[9]  = '{1'b0, 1'b0, 5'd13, 32'h0BADF00D, 2'b00, 1'b0, 32'h0,        1, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b1, 5'd14, 32'h00000001, 2'b11, 1'b0, 32'hCAFEF00D, 2, 1'b1, 32'hCAFEF00D};
        vecs[11] = '{1'b1, 1'b0, 5'd15, 32'h00000000, 2'b10, 1'b0, 32'h11111111, 3, 1'b0, 32'h0};

        rst = 1'b1; in_valid = 1'b0; in_regwrite = 1'b0; in_memtoreg = 1'b0;
        in_dest = '0; in_alu = '0; in_ld_size = '0; in_ld_unsigned = 1'b0;
        dcache_rvalid = 1'b0; dcache_rdata = '0;
        #2;
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_pend", {31'd0, pend_valid}, 32'd0);
        check("rst_err", {31'd0, timeout_err}, 32'd0);
        check("rst_retire", retire_cnt, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // first ALU write: one-cycle latency and a single-cycle pulse
        run_vec(vecs[0]);
        check("alu_we_pulse", {31'd0, rf_we}, 32'd1);
        @(posedge clk); #1;
        check("alu_we_drop", {31'd0, rf_we}, 32'd0);
        check("alu_wdata_hold", rf_wdata, 32'hDEADBEEF);

        for (int i = 1; i < 12; i++) run_vec(vecs[i]);

        // rvalid during the accept cycle is ignored; the later one is written
        in_valid = 1'b1; in_regwrite = 1'b1; in_memtoreg = 1'b1; in_dest = 5'd16;
        in_alu = 32'h0; in_ld_size = 2'b10; in_ld_unsigned = 1'b0;
        dcache_rvalid = 1'b1; dcache_rdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        in_valid = 1'b0; dcache_rvalid = 1'b0;
        @(posedge clk); #1;
        check("early_rv_wait", {31'd0, in_ready}, 32'd0);
        dcache_rvalid = 1'b1; dcache_rdata = 32'h13572468;
        exp_q.push_back({5'd16, 32'h13572468});
        @(posedge clk); #1;
        dcache_rvalid = 1'b0;
        exp_retire++;
        check("early_rv_retire", retire_cnt, exp_retire);

        // rvalid in the last allowed cycle beats the timeout
        start_load(5'd17, 2'b10);
        repeat (63) @(posedge clk);
        #1;
        check("late_rv_waiting", {31'd0, in_ready}, 32'd0);
        dcache_rvalid = 1'b1; dcache_rdata = 32'h24681357;
        exp_q.push_back({5'd17, 32'h24681357});
        @(posedge clk); #1;
        dcache_rvalid = 1'b0;
        exp_retire++;
        check("late_rv_no_err", {31'd0, timeout_err}, 32'd0);
        check("late_rv_idle", {31'd0, fsm_state}, 32'd0);
        check("late_rv_retire", retire_cnt, exp_retire);

        // no response at all: timeout after 64 waiting cycles
        start_load(5'd18, 2'b10);
        repeat (63) @(posedge clk);
        #1;
        check("to_pre_ready", {31'd0, in_ready}, 32'd0);
        check("to_pre_err", {31'd0, timeout_err}, 32'd0);
        check("to_pre_pend", {31'd0, pend_valid}, 32'd1);
        @(posedge clk); #1;
        exp_retire++;
        check("to_err", {31'd0, timeout_err}, 32'd1);
        check("to_pend", {31'd0, pend_valid}, 32'd0);
        check("to_idle", {31'd0, fsm_state}, 32'd0);
        check("to_we", {31'd0, rf_we}, 32'd0);
        check("to_retire", retire_cnt, exp_retire);
        v = vecs[0];
        v.dest = 5'd21; v.alu = 32'h0F0F0F0F; v.exp_data = 32'h0F0F0F0F;
        run_vec(v);
        check("to_sticky", {31'd0, timeout_err}, 32'd1);
        @(posedge clk); #1;
        check("queue_drained", exp_q.size(), 32'd0);

        // reset mid-wait abandons the load; a late rvalid is ignored
        start_load(5'd19, 2'b10);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mrst_we", {31'd0, rf_we}, 32'd0);
        check("mrst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("mrst_wdata", rf_wdata, 32'd0);
        check("mrst_pend", {31'd0, pend_valid}, 32'd0);
        check("mrst_pdest", {27'd0, pend_dest}, 32'd0);
        check("mrst_err", {31'd0, timeout_err}, 32'd0);
        check("mrst_retire", retire_cnt, 32'd0);
        exp_retire = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        dcache_rvalid = 1'b1; dcache_rdata = 32'hFFFF0000;
        @(posedge clk); #1;
        dcache_rvalid = 1'b0;
        @(posedge clk); #1;
        check("mrst_late_we", {31'd0, rf_we}, 32'd0);
        check("mrst_late_retire", retire_cnt, 32'd0);
        check("mrst_late_ready", {31'd0, in_ready}, 32'd1);

        // back-to-back ALU instructions, one per cycle
        wc = write_cnt;
        in_valid = 1'b1; in_regwrite = 1'b1; in_memtoreg = 1'b0;
        for (int i = 0; i < 10; i++) begin
            logic [4:0]  d;
            logic [31:0] a;
            d = 5'($urandom_range(1, 31));
            a = $urandom;
            in_dest = d; in_alu = a;
            exp_q.push_back({d, a});
            @(posedge clk); #1;
            exp_retire++;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_retire", retire_cnt, exp_retire);
        check("b2b_writes", write_cnt - wc, 32'd10);
        check("b2b_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
